imem_loader_fetch: RTL and testbench
====================================

Name: imem_loader_fetch

Overview:
- Parametrised, fully synchronous instruction memory with two ports: a burst loader write port and a pipelined fetch read port, both using valid/ready handshakes.
- Sits between the program-load path (testbench or boot loader) and the core fetch stage.
- Adds the following over the previous instruction store:
  - explicit load/run sequencing;
  - backpressure on fetch;
  - power-of-two address wrap instead of modulo-15 indexing;
  - defined read latency.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 4, address width; depth is 2**ADDR_W words (derived localparam DEPTH, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_start  in  1  request a load burst; sampled with ld_base and ld_len.
- ld_base  in  ADDR_W  first word address of the burst.
- ld_len  in  ADDR_W+1  number of words; 0 means ignore; values above DEPTH are clamped to DEPTH.
- ld_valid  in  1  ld_data valid.
- ld_data  in  DATA_W  word to write.
- ld_ready  out  1  loader may transfer this cycle.
- ld_done  out  1  one-cycle pulse after the last burst word is written.
- fetch_valid  in  1  fetch request.
- fetch_pc  in  ADDR_W  fetch address.
- fetch_ready  out  1  fetch accepted this cycle when fetch_valid is also high.
- ins_valid  out  1  ins_data holds a fetched word.
- ins_data  out  DATA_W  fetched word.
- ins_ready  in  1  consumer takes ins_data.
- busy  out  1  high while in LOAD.
- ins_perr  out  1  parity error flag qualified by ins_valid; tied 0 unless IMEM_PARITY_EN is defined.

Behaviour:
- Reset values: state=IDLE; ld_ready, ld_done, fetch_ready, ins_valid, busy and ins_perr are 0; ins_data is 0. The memory array is not reset.
- States and transitions:
  - IDLE: no program loaded; fetch_ready=0. ld_start with ld_len!=0 goes to LOAD.
  - LOAD: busy=1, ld_ready=1. Each ld_valid&&ld_ready writes mem[wr_addr] and increments wr_addr modulo DEPTH, so a burst from ld_base near the top wraps to 0. The remaining counter decrements per write. On the final write, ld_done pulses high the next cycle and the state goes to RUN. ld_start is ignored in LOAD. ld_valid low stalls the burst with no timeout.
  - RUN: ld_start with ld_len!=0 goes to LOAD; it has priority over a same-cycle fetch, so fetch_ready is low whenever ld_start is high.
- Fetch handshake:
  - fetch_ready = (state==RUN) && !ld_start && (!ins_valid || ins_ready).
  - An accepted fetch registers mem[fetch_pc] into ins_data with ins_valid=1 on the next edge; latency is exactly 1 cycle.
  - Throughput is 1 word/cycle with ins_ready held high.
  - With ins_ready low, ins_valid and ins_data hold stable and fetch_ready stays low.
  - ins_valid clears when ins_ready is high and no new fetch is accepted.
- Read/write collision cannot occur: fetch is blocked outside RUN. A word already held in ins_data when a load starts stays valid until consumed.
- ld_len clamp: writing DEPTH words overwrites the whole array once. ld_len>DEPTH never writes any address twice.
- Reset mid-load: the state returns to IDLE and the partially loaded contents remain. A new load is required before any fetch.
- ld_done and ld_ready are registered outputs. fetch_ready is combinational from state, ld_start, ins_valid and ins_ready.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each array word is DATA_W+1 bits wide, storing even parity of ld_data on write.
  - On fetch, parity is recomputed and ins_perr is registered alongside ins_data: 1 on mismatch, with the same valid/hold rules as ins_data.
  - A hierarchical force on the array must be able to produce ins_perr=1.
- Not defined: the array is DATA_W bits wide and ins_perr is constant 0. The port list is identical in both builds.

Decomposition:
- Package imem_pkg:
  - state enum {IDLE, LOAD, RUN};
  - default DATA_W and ADDR_W constants;
  - parity function.
- Sub-module imem_array: storage with one synchronous write port and one synchronous registered read port, parametrised by DATA_W (+1 under IMEM_PARITY_EN) and ADDR_W.
- The top level holds the FSM, the burst counters and the output hold logic.

Test Plan:
- Reset then fetch_valid=1 pc=3 -> fetch_ready=0, ins_valid=0 while IDLE; all outputs 0 during and after rst_n low.
- ld_start base=0 len=16 with data=i*3 -> 16 writes, then ld_done pulses 1 cycle; fetch pc 0..15 back-to-back with ins_ready=1 -> ins_data=0,3,...,45, one word per cycle, latency 1.
- Wrap: load base=14 len=4 data A1,A2,A3,A4 -> fetch pc 14,15,0,1 returns A1,A2,A3,A4; ld_len=20 -> exactly 16 writes.
- Backpressure: ins_ready=0 for 3 cycles after fetch pc=5 -> ins_data stable, fetch_ready=0; on release the next fetch issues.
- ld_start asserted in RUN simultaneously with fetch_valid -> fetch not accepted, busy=1 next cycle; rst_n pulse mid-burst -> IDLE, ld_ready=0.
- IMEM_PARITY_EN: flip one stored bit at pc=7 -> fetch gives ins_perr=1 with ins_valid; clean word gives ins_perr=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory loader/fetch block.
package imem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic parity64(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage with one synchronous write port and one registered read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned WORD_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register only updates on an accepted fetch, so it doubles as the output hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader_fetch.sv
// Instruction memory with burst loader and 1-cycle-latency fetch port.
// Optional stored parity and ins_perr flag when IMEM_PARITY_EN is defined.
module imem_loader_fetch
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_data,
    input  logic              ins_ready,
    output logic              busy,
    output logic              ins_perr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   left_q, left_d;
    logic              ld_ready_q, ld_ready_d;
    logic              ld_done_q, ld_done_d;
    logic              ins_valid_q, ins_valid_d;
    logic              start_ok;
    logic              wr_fire;
    logic              fetch_fire;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;

    assign start_ok    = ld_start && (ld_len != '0);
    assign wr_fire     = ld_valid && ld_ready_q;
    assign fetch_ready = (state_q == RUN) && !ld_start && (!ins_valid_q || ins_ready);
    assign fetch_fire  = fetch_valid && fetch_ready;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        left_d    = left_q;
        ld_done_d = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (start_ok) begin
                    state_d   = LOAD;
                    wr_addr_d = ld_base;
                    left_d    = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
                end
            end
            LOAD: begin
                if (wr_fire) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    left_d    = left_q - ONE_L;
                    if (left_q == ONE_L) begin
                        state_d   = RUN;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ld_ready_d = (state_d == LOAD);

        if (fetch_fire) begin
            ins_valid_d = 1'b1;
        end else if (ins_ready) begin
            ins_valid_d = 1'b0;
        end else begin
            ins_valid_d = ins_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            left_q      <= '0;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
            ins_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            left_q      <= left_d;
            ld_ready_q  <= ld_ready_d;
            ld_done_q   <= ld_done_d;
            ins_valid_q <= ins_valid_d;
        end
    end

`ifdef IMEM_PARITY_EN
    assign wdata    = {parity64(64'(ld_data)), ld_data};
    assign ins_perr = ins_valid_q && (parity64(64'(rdata[DATA_W-1:0])) != rdata[DATA_W]);
`else
    assign wdata    = ld_data;
    assign ins_perr = 1'b0;
`endif

    imem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_fire),
        .waddr_i (wr_addr_q),
        .wdata_i (wdata),
        .re_i    (fetch_fire),
        .raddr_i (fetch_pc),
        .rdata_o (rdata)
    );

    assign ld_ready  = ld_ready_q;
    assign ld_done   = ld_done_q;
    assign ins_valid = ins_valid_q;
    assign ins_data  = rdata[DATA_W-1:0];
    assign busy      = (state_q == LOAD);

endmodule

// File: tb/tb_imem_loader_fetch.sv
// Directed + randomized bench for imem_loader_fetch against a behavioural memory model.
module tb_imem_loader_fetch;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic          fetch_ready;
    logic          ins_valid;
    logic [DW-1:0] ins_data;
    logic          ins_ready;
    logic          busy;
    logic          ins_perr;

    always #5 clk = ~clk;

    imem_loader_fetch #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_len      (ld_len),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_ready   (ins_ready),
        .busy        (busy),
        .ins_perr    (ins_perr)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: program contents plus a few flags describing where the loader is.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_bad [DEPTH];
    bit            m_load, m_run, m_insv, m_insbad, m_done;
    int            m_left, m_ptr, nwrites;
    logic [DW-1:0] m_insd;
    logic [DW-1:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        chk("ld_ready", 32'(ld_ready), 32'(m_load));
        chk("busy", 32'(busy), 32'(m_load));
        chk("ld_done", 32'(ld_done), 32'(m_done));
        chk("ins_valid", 32'(ins_valid), 32'(m_insv));
        chk("ins_data", 32'(ins_data), 32'(m_insd));
        chk("ins_perr", 32'(ins_perr), 32'(m_insv && m_insbad));
    endtask

    // One clock: inputs are already driven; check comb output, advance model, check registers.
    task automatic cycle();
        bit exp_fr;
        #1;
        exp_fr = m_run && !ld_start && (!m_insv || ins_ready);
        chk("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
        if (fetch_valid && exp_fr) begin
            m_insd   = m_mem[fetch_pc];
            m_insbad = m_bad[fetch_pc];
            m_insv   = 1'b1;
        end else if (ins_ready) begin
            m_insv = 1'b0;
        end
        m_done = 1'b0;
        if (m_load) begin
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                m_bad[m_ptr] = 1'b0;
                nwrites++;
                m_ptr = (m_ptr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) begin
                    m_load = 1'b0;
                    m_run  = 1'b1;
                    m_done = 1'b1;
                end
            end
        end else if (ld_start && ld_len != 0) begin
            m_load = 1'b1;
            m_run  = 1'b0;
            m_ptr  = int'(ld_base);
            m_left = (int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
        end
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'(0));
        chk({tag, "_ld_done"}, 32'(ld_done), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_ins_valid"}, 32'(ins_valid), 32'(0));
        chk({tag, "_ins_data"}, 32'(ins_data), 32'(0));
        chk({tag, "_ins_perr"}, 32'(ins_perr), 32'(0));
        chk({tag, "_fetch_ready"}, 32'(fetch_ready), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        m_load = 0; m_run = 0; m_insv = 0; m_insbad = 0; m_done = 0; m_insd = '0;
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic load(input int base, input int len, input bit gaps);
        int idx = 0;
        int budget = 200;
        int exp_w;
        logic [31:0] b32, l32;
        exp_w = (len > DEPTH) ? DEPTH : len;
        b32 = 32'(base);
        l32 = 32'(len);
        nwrites = 0;
        fetch_valid = 1'b0;
        ld_start = 1'b1; ld_base = b32[AW-1:0]; ld_len = l32[AW:0]; ld_valid = 1'b0;
        cycle();
        ld_start = 1'b0;
        while (m_load && budget > 0) begin
            ld_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            ld_data  = (idx < wq.size()) ? wq[idx] : 8'($urandom);
            cycle();
            if (ld_valid) idx++;
            budget--;
        end
        ld_valid = 1'b0;
        chk("load_budget", 32'(budget > 0), 32'(1));
        chk("write_count", 32'(nwrites), 32'(exp_w));
    endtask

    initial begin
        logic [DW-1:0] held;
        int pcs[4] = '{14, 15, 0, 1};
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        ld_start = 0; ld_base = '0; ld_len = '0; ld_valid = 0; ld_data = '0;
        fetch_valid = 1'b1; fetch_pc = 4'd3; ins_ready = 1'b1;

        // Reset, then fetch attempts while IDLE are refused
        do_reset();
        repeat (3) cycle();
        fetch_valid = 1'b0;

        // Full-depth load of i*3 with random gaps, then back-to-back fetch
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(8'(i * 3));
        load(0, 16, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            fetch_valid = 1'b1; fetch_pc = 4'(i); ins_ready = 1'b1;
            cycle();
            chk("seq_data", 32'(ins_data), 32'(i * 3));
        end
        fetch_valid = 1'b0;
        cycle();

        // Address wrap from the top of the array
        wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        load(14, 4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            fetch_valid = 1'b1; fetch_pc = 4'(pcs[k]);
            cycle();
            chk("wrap_data", 32'(ins_data), 32'(wq[k]));
        end
        fetch_valid = 1'b0;

        // Length clamp and zero-length ignore
        wq.delete();
        load(5, 20, 1'b1);
        load(3, 0, 1'b0);

        // Backpressure on the fetch output
        fetch_valid = 1'b1; fetch_pc = 4'd5; ins_ready = 1'b1;
        cycle();
        held = ins_data;
        ins_ready = 1'b0; fetch_pc = 4'd9;
        repeat (3) begin
            cycle();
            chk("bp_hold", 32'(ins_data), 32'(held));
            chk("bp_fetch_ready", 32'(fetch_ready), 32'(0));
        end
        ins_ready = 1'b1;
        cycle();
        chk("bp_release", 32'(ins_data), 32'(m_mem[9]));

        // Load request beats a same-cycle fetch; reset lands mid-burst
        fetch_valid = 1'b1; fetch_pc = 4'd2; ld_start = 1'b1; ld_base = 4'd0; ld_len = 5'd8;
        cycle();
        chk("prio_busy", 32'(busy), 32'(1));
        ld_start = 1'b0; fetch_valid = 1'b0;
        ld_valid = 1'b1;
        repeat (3) begin
            ld_data = 8'($urandom);
            cycle();
        end
        ld_valid = 1'b0;
        do_reset();
        chk("midrst_ld_ready", 32'(ld_ready), 32'(0));
        fetch_valid = 1'b1; fetch_pc = 4'd3;
        repeat (2) cycle();
        fetch_valid = 1'b0;

        wq.delete();
        load(0, 16, 1'b1);

`ifdef IMEM_PARITY_EN
        dut.u_array.mem[7] = dut.u_array.mem[7] ^ 9'h001;
        m_mem[7] = m_mem[7] ^ 8'h01;
        m_bad[7] = 1'b1;
        fetch_valid = 1'b1; fetch_pc = 4'd7; ins_ready = 1'b1;
        cycle();
        chk("perr_bad", 32'(ins_perr), 32'(1));
        fetch_pc = 4'd6;
        cycle();
        chk("perr_clean", 32'(ins_perr), 32'(0));
        fetch_valid = 1'b0;
`endif

        // Random traffic against the model
        repeat (400) begin
            ld_start    = ($urandom_range(30) == 0);
            ld_base     = 4'($urandom);
            ld_len      = 5'($urandom_range(20));
            ld_valid    = ($urandom_range(3) != 0);
            ld_data     = 8'($urandom);
            fetch_valid = ($urandom_range(3) != 0);
            fetch_pc    = 4'($urandom);
            ins_ready   = ($urandom_range(3) != 0);
            cycle();
        end

        ld_start = 1'b0; ld_valid = 1'b0; fetch_valid = 1'b0; ins_ready = 1'b1;
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
